// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch / PC unit.
package fetch_pkg;

   typedef enum logic [1:0] {
      S_REQ   = 2'd0,
      S_WAIT  = 2'd1,
      S_OUT   = 2'd2,
      S_FAULT = 2'd3
   } fetch_state_e;

   localparam logic [31:0] INSTR_BYTES      = 32'd4;
   localparam logic [31:0] ALIGN_MASK       = INSTR_BYTES - 32'd1;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory request/response bus plus the fetch->decode handshake.
// master: the fetch unit side; slave: the memory/decode side.
interface fetch_pc_unit_if;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        if_valid;
   logic        id_ready;

   modport master (
      output imem_req, imem_addr, if_instr, if_pc, if_valid,
      input  imem_gnt, imem_rvalid, imem_rdata, id_ready
   );

   modport slave (
      input  imem_req, imem_addr, if_instr, if_pc, if_valid,
      output imem_gnt, imem_rvalid, imem_rdata, id_ready
   );

endinterface

// File: rtl/fetch_pc_unit.sv
// Program counter and single-outstanding instruction fetch sequencer.
// Optional feature macro: FETCH_ALIGN_CHECK_EN -- a misaligned PC load parks
// the unit in S_FAULT (exit only by reset) and adds the misalign_fault port.
// Without it, loaded PCs are forced word aligned.
module fetch_pc_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [31:0]       next_pc,
   input  logic              flush,
   fetch_pc_unit_if.master   bus,
   output logic [31:0]       pc,
   output logic [31:0]       pc_plus4
`ifdef FETCH_ALIGN_CHECK_EN
   ,
   output logic              misalign_fault
`endif
);

   fetch_state_e r_state, w_state_nx;
   logic [31:0]  r_pc, r_instr, r_if_pc;
   logic         r_valid, r_drop;
   logic         w_load, w_capture, w_drop_set, w_drop_clr;
   logic [31:0]  w_load_pc;

`ifdef FETCH_ALIGN_CHECK_EN
   assign w_load_pc = next_pc;
`else
   assign w_load_pc = next_pc & ~ALIGN_MASK;
`endif

   assign pc            = r_pc;
   assign pc_plus4      = r_pc + INSTR_BYTES;  // wraps mod 2^32
   assign bus.imem_addr = r_pc;
   assign bus.if_instr  = r_instr;
   assign bus.if_pc     = r_if_pc;
   assign bus.if_valid  = r_valid;

   // State register
   always_ff @(posedge clk) begin
      if (!reset_n) r_state <= S_REQ;
      else          r_state <= w_state_nx;
   end

   // Next-state logic and the datapath events (PC load, capture, drop) it implies
   always_comb begin
      w_state_nx = r_state;
      w_load     = 1'b0;
      w_capture  = 1'b0;
      w_drop_set = 1'b0;
      w_drop_clr = 1'b0;
      case (r_state)
         S_REQ: begin
            // flush beats a same-cycle grant; the grant is simply not taken
            if (flush)             w_load     = 1'b1;
            else if (bus.imem_gnt) w_state_nx = S_WAIT;
         end
         S_WAIT: begin
            if (bus.imem_rvalid) begin
               if (r_drop || flush) begin
                  w_drop_clr = 1'b1;
                  w_load     = 1'b1;
                  w_state_nx = S_REQ;
               end else begin
                  w_capture  = 1'b1;
                  w_state_nx = S_OUT;
               end
            end else if (flush) begin
               // response still owed by memory: remember to discard it
               w_drop_set = 1'b1;
            end
         end
         S_OUT: begin
            if (flush || (r_valid && bus.id_ready)) begin
               w_load     = 1'b1;
               w_state_nx = S_REQ;
            end
         end
         default: ;  // S_FAULT is sticky until reset
      endcase
`ifdef FETCH_ALIGN_CHECK_EN
      if (w_load && (next_pc[1:0] != 2'b00)) w_state_nx = S_FAULT;
`endif
   end

   // Outputs decoded from the state
   always_comb begin
      bus.imem_req = (r_state == S_REQ);
`ifdef FETCH_ALIGN_CHECK_EN
      misalign_fault = (r_state == S_FAULT);
`endif
   end

   // PC, fetched instruction register and drop flag
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_pc    <= RESET_PC;
         r_instr <= 32'h0;
         r_if_pc <= 32'h0;
         r_valid <= 1'b0;
         r_drop  <= 1'b0;
      end else begin
         if (w_load) r_pc <= w_load_pc;
         if (w_capture) begin
            r_instr <= bus.imem_rdata;
            r_if_pc <= r_pc;
            r_valid <= 1'b1;
         end else if (w_load) begin
            r_valid <= 1'b0;
         end
         if (w_drop_set)      r_drop <= 1'b1;
         else if (w_drop_clr) r_drop <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed scenarios plus a randomized
// run against a transaction-level model of the fetch sequence.
module tb_fetch_pc_unit;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] next_pc = 32'h0;
   logic        flush = 1'b0;
   logic [31:0] pc, pc_plus4;
`ifdef FETCH_ALIGN_CHECK_EN
   logic        misalign_fault;
`endif
   int checks = 0;
   int errors = 0;
   logic [31:0] cur;

   fetch_pc_unit_if bus();

   fetch_pc_unit dut (
      .clk(clk),
      .reset_n(reset_n),
      .next_pc(next_pc),
      .flush(flush),
      .bus(bus),
      .pc(pc),
      .pc_plus4(pc_plus4)
`ifdef FETCH_ALIGN_CHECK_EN
      ,
      .misalign_fault(misalign_fault)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A5A, a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   // Apply inputs for one cycle, then land 1 time unit after the next edge.
   task automatic drive(input logic g, input logic rv, input logic ir, input logic fl,
                        input logic [31:0] npc, input logic [31:0] rd);
      bus.imem_gnt    = g;
      bus.imem_rvalid = rv;
      bus.id_ready    = ir;
      flush           = fl;
      next_pc         = npc;
      bus.imem_rdata  = rd;
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      drive(0, 0, 0, 0, 32'h0, 32'h0);
      drive(0, 0, 0, 0, 32'h0, 32'h0);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      drive(1, 0, 0, 0, 32'h4, 32'h0);
      drive(0, 1, 0, 0, 32'h4, mem_word(32'h0));
      checks++;
      if (bus.if_valid !== 1'b1)
         $display("FAIL pre_reset_valid got=%b exp=1", bus.if_valid);
      do_reset();
      checks++;
      if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL rst_if_valid got=%b exp=0", bus.if_valid); end
      checks++;
      if (bus.if_instr !== 32'h0) begin errors++; $display("FAIL rst_if_instr got=%h exp=0", bus.if_instr); end
      checks++;
      if (bus.if_pc !== 32'h0) begin errors++; $display("FAIL rst_if_pc got=%h exp=0", bus.if_pc); end
      checks++;
      if (pc !== 32'h0 || bus.imem_addr !== 32'h0) begin
         errors++; $display("FAIL rst_pc got=%h/%h exp=0", pc, bus.imem_addr);
      end
      checks++;
      if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL rst_req got=%b exp=1", bus.imem_req); end
      checks++;
      if (pc_plus4 !== 32'h4) begin errors++; $display("FAIL rst_pc_plus4 got=%h exp=4", pc_plus4); end
`ifdef FETCH_ALIGN_CHECK_EN
      checks++;
      if (misalign_fault !== 1'b0) begin errors++; $display("FAIL rst_fault got=%b exp=0", misalign_fault); end
`endif
      cur = 32'h0;
   endtask

   // gnt and rvalid answered in one cycle each: one instruction every 3 cycles
   task automatic test_basic();
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (bus.imem_req !== 1'b1 || bus.imem_addr !== cur) begin
            errors++; $display("FAIL basic_req got=%b/%h exp=1/%h", bus.imem_req, bus.imem_addr, cur);
         end
         drive(1, 0, 0, 0, cur + 32'd4, 32'h0);
         checks++;
         if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL basic_wait_req got=%b exp=0", bus.imem_req); end
         drive(0, 1, 0, 0, cur + 32'd4, mem_word(cur));
         checks++;
         if (bus.if_valid !== 1'b1 || bus.if_pc !== cur || bus.if_instr !== mem_word(cur)) begin
            errors++;
            $display("FAIL basic_out got=%b/%h/%h exp=1/%h/%h", bus.if_valid, bus.if_pc, bus.if_instr,
                     cur, mem_word(cur));
         end
         drive(0, 0, 1, 0, cur + 32'd4, 32'h0);
         cur = cur + 32'd4;
      end
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hC) begin
         errors++; $display("FAIL basic_after got=%b/%h exp=1/0000000c", bus.imem_req, bus.imem_addr);
      end
   endtask

   task automatic test_stall();
      drive(1, 0, 0, 0, cur + 32'd4, 32'h0);
      drive(0, 1, 0, 0, cur + 32'd4, mem_word(cur));
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (bus.if_valid !== 1'b1 || bus.if_pc !== cur || bus.if_instr !== mem_word(cur) ||
             bus.imem_req !== 1'b0 || pc !== cur) begin
            errors++;
            $display("FAIL stall_hold got=%b/%h/%h/%b/%h exp=1/%h/%h/0/%h", bus.if_valid, bus.if_pc,
                     bus.if_instr, bus.imem_req, pc, cur, mem_word(cur), cur);
         end
         drive(0, 0, 0, 0, 32'hDEAD_BEE0, 32'h0);
      end
      drive(0, 0, 1, 0, cur + 32'd4, 32'h0);
      cur = cur + 32'd4;
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== cur || bus.if_valid !== 1'b0) begin
         errors++; $display("FAIL stall_advance got=%b/%h/%b exp=1/%h/0", bus.imem_req, bus.imem_addr,
                            bus.if_valid, cur);
      end
   endtask

   task automatic test_flush_wait();
      drive(1, 0, 0, 0, cur + 32'd4, 32'h0);
      drive(0, 0, 0, 1, 32'h100, 32'h0);
      drive(0, 0, 0, 0, 32'h100, 32'h0);
      checks++;
      if (bus.if_valid !== 1'b0 || bus.imem_req !== 1'b0) begin
         errors++; $display("FAIL fwait_pending got=%b/%b exp=0/0", bus.if_valid, bus.imem_req);
      end
      drive(0, 1, 1, 0, 32'h100, mem_word(cur));
      checks++;
      if (bus.if_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin
         errors++; $display("FAIL fwait_drop got=%b/%b/%h exp=0/1/00000100", bus.if_valid,
                            bus.imem_req, bus.imem_addr);
      end
      cur = 32'h100;
   endtask

   task automatic test_flush_out();
      drive(1, 0, 0, 0, cur + 32'd4, 32'h0);
      drive(0, 1, 0, 0, cur + 32'd4, mem_word(cur));
      checks++;
      if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h100) begin
         errors++; $display("FAIL fout_valid got=%b/%h exp=1/00000100", bus.if_valid, bus.if_pc);
      end
      drive(0, 0, 1, 1, 32'h40, 32'h0);
      checks++;
      if (bus.if_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h40) begin
         errors++; $display("FAIL fout_kill got=%b/%b/%h exp=0/1/00000040", bus.if_valid,
                            bus.imem_req, bus.imem_addr);
      end
      drive(1, 0, 0, 0, 32'h44, 32'h0);
      drive(0, 1, 0, 0, 32'h44, mem_word(32'h40));
      checks++;
      if (bus.if_pc !== 32'h40 || bus.if_instr !== mem_word(32'h40)) begin
         errors++; $display("FAIL fout_refetch got=%h/%h exp=00000040/%h", bus.if_pc, bus.if_instr,
                            mem_word(32'h40));
      end
      drive(0, 0, 1, 0, 32'h44, 32'h0);
      cur = 32'h44;
   endtask

   task automatic test_wrap();
      logic [31:0] top, wrapped;
      top = 32'hFFFF_FFFC;
      wrapped = top + 32'd4;
      // flush together with gnt: flush must win and the grant is not taken
      drive(1, 0, 0, 1, top, 32'h0);
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== top || pc_plus4 !== 32'h0) begin
         errors++; $display("FAIL wrap_pc got=%b/%h/%h exp=1/fffffffc/00000000", bus.imem_req,
                            bus.imem_addr, pc_plus4);
      end
      drive(1, 0, 0, 0, wrapped, 32'h0);
      drive(0, 1, 0, 0, wrapped, mem_word(top));
      checks++;
      if (bus.if_valid !== 1'b1 || bus.if_pc !== top) begin
         errors++; $display("FAIL wrap_out got=%b/%h exp=1/fffffffc", bus.if_valid, bus.if_pc);
      end
      drive(0, 0, 1, 0, wrapped, 32'h0);
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
         errors++; $display("FAIL wrap_next got=%b/%h exp=1/00000000", bus.imem_req, bus.imem_addr);
      end
      cur = 32'h0;
   endtask

   task automatic test_align();
      drive(1, 0, 0, 0, 32'h4, 32'h0);
      drive(0, 1, 0, 0, 32'h4, mem_word(cur));
      drive(0, 0, 1, 0, 32'h102, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (misalign_fault !== 1'b1 || bus.imem_req !== 1'b0 || bus.if_valid !== 1'b0 ||
             pc !== 32'h102) begin
            errors++; $display("FAIL align_fault got=%b/%b/%b/%h exp=1/0/0/00000102", misalign_fault,
                               bus.imem_req, bus.if_valid, pc);
         end
         drive(1, 1, 1, 1, 32'h200, 32'h0);
      end
      do_reset();
      checks++;
      if (misalign_fault !== 1'b0 || bus.imem_req !== 1'b1) begin
         errors++; $display("FAIL align_reset got=%b/%b exp=0/1", misalign_fault, bus.imem_req);
      end
`else
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin
         errors++; $display("FAIL align_force got=%b/%h exp=1/00000100", bus.imem_req, bus.imem_addr);
      end
`endif
   endtask

   // Random gnt/rvalid delays, decode stalls and flushes. The model tracks only
   // fetch transactions: which address must be requested next, which response
   // is still owed, whether the in-flight instruction was killed, and whether
   // decode should currently see a valid instruction.
   task automatic test_random();
      logic [31:0] exp_addr, last_addr, target, npc, rd;
      bit flushed, in_flight, killed, resp_pending, exp_valid;
      bit g, rv, ir, fl, accept, grant;
      int wait_cnt;
      exp_addr = 32'h0; last_addr = 32'h0; target = 32'h0;
      flushed = 0; in_flight = 0; killed = 0; resp_pending = 0; exp_valid = 0; wait_cnt = 0;
      do_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         checks++;
         if (bus.if_valid !== exp_valid || bus.imem_req !== !in_flight) begin
            errors++; $display("FAIL rnd_ctrl cyc=%0d got=%b/%b exp=%b/%b", cyc, bus.if_valid,
                               bus.imem_req, exp_valid, !in_flight);
         end
         if (exp_valid) begin
            checks++;
            if (bus.if_pc !== last_addr || bus.if_instr !== mem_word(last_addr)) begin
               errors++; $display("FAIL rnd_instr cyc=%0d got=%h/%h exp=%h/%h", cyc, bus.if_pc,
                                  bus.if_instr, last_addr, mem_word(last_addr));
            end
         end
         if (!in_flight) begin
            checks++;
            if (bus.imem_addr !== exp_addr || pc_plus4 !== exp_addr + 32'd4) begin
               errors++; $display("FAIL rnd_addr cyc=%0d got=%h/%h exp=%h/%h", cyc, bus.imem_addr,
                                  pc_plus4, exp_addr, exp_addr + 32'd4);
            end
         end
         fl = ($urandom_range(0, 9) == 0);
         g  = bus.imem_req && ($urandom_range(0, 2) != 0);
         rv = resp_pending && (wait_cnt == 0);
         ir = ($urandom_range(0, 3) != 0);
         if (fl) begin
            target  = $urandom & 32'hFFFF_FFFC;
            flushed = 1;
         end
         npc = flushed ? target : last_addr + 32'd4;
         rd  = rv ? mem_word(last_addr) : $urandom;
         accept = exp_valid && ir && !fl;
         grant  = g && !fl;
         if (resp_pending && !rv) wait_cnt--;
         if (fl) begin
            exp_addr = target;
            if (in_flight) killed = 1;
            if (exp_valid) begin exp_valid = 0; in_flight = 0; end
         end
         if (rv) begin
            resp_pending = 0;
            if (killed) in_flight = 0;
            else        exp_valid = 1;
         end
         if (accept) begin
            exp_valid = 0;
            in_flight = 0;
            exp_addr  = last_addr + 32'd4;
         end
         if (grant) begin
            last_addr    = exp_addr;
            in_flight    = 1;
            killed       = 0;
            flushed      = 0;
            resp_pending = 1;
            wait_cnt     = $urandom_range(0, 3);
         end
         drive(g, rv, ir, fl, npc, rd);
      end
   endtask

   initial begin
      bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.id_ready = 1'b0; bus.imem_rdata = 32'h0;
      test_reset();
      test_basic();
      test_stall();
      test_flush_wait();
      test_flush_out();
      test_wrap();
      test_align();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
